// File: rtl/class_frame_sequencer.sv
// Walks the class hypervector generator over every (class, frame) pair, class-major,
// and streams the registered frames with tags on a valid/ready output.
module class_frame_sequencer #(
  parameter int NUM_CLASSES        = 10,
  parameter int NUM_FRAMES         = 3,
  parameter int DI_PARALLEL_W_BITS = 100,
  parameter int CLASS_ID_W         = 4,
  parameter int FRAME_IDX_W        = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic [CLASS_ID_W-1:0]         gen_frame_id,
  output logic [FRAME_IDX_W-1:0]        gen_frame_index,
  input  logic [DI_PARALLEL_W_BITS-1:0] gen_class_vec,
  output logic                          cv_valid,
  input  logic                          cv_ready,
  output logic [DI_PARALLEL_W_BITS-1:0] cv_data,
  output logic [CLASS_ID_W-1:0]         cv_class_id,
  output logic [FRAME_IDX_W-1:0]        cv_frame_index,
  output logic                          cv_last_frame,
  output logic                          cv_last_class
);

  localparam logic [CLASS_ID_W-1:0]  LAST_CLS = CLASS_ID_W'(NUM_CLASSES - 1);
  localparam logic [FRAME_IDX_W-1:0] LAST_FRM = FRAME_IDX_W'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CLASS_ID_W-1:0]  cls_ctr;
  logic [FRAME_IDX_W-1:0] frm_ctr;
  logic                   cap;
  logic                   hs;
  logic                   frm_last;
  logic                   pair_last;

  assign cap       = (state == RUN) && (!cv_valid || cv_ready);
  assign hs        = cv_valid && cv_ready;
  assign frm_last  = (frm_ctr == LAST_FRM);
  assign pair_last = frm_last && (cls_ctr == LAST_CLS);

  assign busy            = (state != IDLE);
  assign gen_frame_id    = cls_ctr;
  assign gen_frame_index = frm_ctr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start)            state_nxt = RUN;
        RUN:     if (cap && pair_last) state_nxt = DRAIN;
        DRAIN:   if (hs)               state_nxt = IDLE;
        default:                       state_nxt = IDLE;
      endcase
    end
  end

  // Counters rest at (0,0) outside a sweep so the generator idles on the first pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_ctr <= '0;
      frm_ctr <= '0;
    end else if (abort || (state == IDLE) || ((state == DRAIN) && hs)) begin
      cls_ctr <= '0;
      frm_ctr <= '0;
    end else if (cap && !pair_last) begin
      if (frm_last) begin
        frm_ctr <= '0;
        cls_ctr <= cls_ctr + 1'b1;
      end else begin
        frm_ctr <= frm_ctr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv_valid       <= 1'b0;
      cv_data        <= '0;
      cv_class_id    <= '0;
      cv_frame_index <= '0;
      cv_last_frame  <= 1'b0;
      cv_last_class  <= 1'b0;
    end else if (abort) begin
      cv_valid <= 1'b0;
    end else if (cap) begin
      cv_valid       <= 1'b1;
      cv_data        <= gen_class_vec;
      cv_class_id    <= cls_ctr;
      cv_frame_index <= frm_ctr;
      cv_last_frame  <= frm_last;
      cv_last_class  <= pair_last;
    end else if (hs) begin
      cv_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= (state == DRAIN) && hs && !abort;
  end

endmodule

// File: doc/class_frame_sequencer.md
# class_frame_sequencer

Sequencer that walks the class hypervector generator over every (class, frame) pair and streams the resulting class-vector frames to the downstream similarity/search datapath. It drives the generator's `frame_id` and `frame_index` select inputs, registers each returned frame with its tags, and presents them on a valid/ready stream with backpressure. Order is class-major with the frame index as the inner loop. The block sits between the inference control FSM and the similarity accumulator.

## Interface
- `NUM_CLASSES`, default 10: number of classes, legal range 1..2^CLASS_ID_W.
- `NUM_FRAMES`, default 3: frames per class vector, legal range 1..2^FRAME_IDX_W.
- `DI_PARALLEL_W_BITS`, default 100: frame width in bits.
- `CLASS_ID_W`, default 4: width of the class id.
- `FRAME_IDX_W`, default 2: width of the frame index.

Ports:
- `clk` in 1: the single clock; everything is on the rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `start` in 1: pulse that starts one full sweep; sampled only in IDLE.
- `abort` in 1: cancels the sweep; takes effect in any state.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse after the last beat is accepted.
- `gen_frame_id` out CLASS_ID_W: class select driven to the generator.
- `gen_frame_index` out FRAME_IDX_W: frame select driven to the generator.
- `gen_class_vec` in DI_PARALLEL_W_BITS: combinational frame returned by the generator.
- `cv_valid` out 1: output beat is valid.
- `cv_ready` in 1: downstream accepts the beat.
- `cv_data` out DI_PARALLEL_W_BITS: class-vector frame.
- `cv_class_id` out CLASS_ID_W: tag giving the class of `cv_data`.
- `cv_frame_index` out FRAME_IDX_W: tag giving the frame of `cv_data`.
- `cv_last_frame` out 1: this beat is frame NUM_FRAMES-1 of its class.
- `cv_last_class` out 1: this beat is the final beat of the sweep.

## Operation
- FSM states:
  - IDLE: `start` & !`abort` → RUN.
  - RUN: capture of the final pair → DRAIN.
  - DRAIN: handshake of the final beat → IDLE, with a `done` pulse.
  - `abort` moves any state to IDLE.
- Address counters:
  - `cls_ctr` and `frm_ctr` drive `gen_frame_id` and `gen_frame_index` directly from registers.
  - Both are cleared to 0 on start.
  - The generator is combinational, so the frame is valid in the same cycle as the address.
- Capture condition: cap = RUN & (!`cv_valid` | `cv_ready`).
- On cap:
  - Load `cv_data` ← `gen_class_vec` and load the tags from the counters.
  - Compute the last flags by comparing against NUM_FRAMES-1 and NUM_CLASSES-1.
  - Set `cv_valid` = 1.
- Counter advance on cap:
  - `frm_ctr`++ .
  - If `frm_ctr` == NUM_FRAMES-1, then `frm_ctr` ← 0 and `cls_ctr`++ .
  - On the final pair the counters do not advance; the state moves to DRAIN.
- On a handshake with no cap (DRAIN, or IDLE after abort): `cv_valid` ← 0.
- Output stability: while `cv_valid` & !`cv_ready`, `cv_data`, all tags and flags hold stable, and the counters hold.
- Counter wrap: counters never run past NUM_CLASSES-1 or NUM_FRAMES-1, including for non-power-of-two parameters.
- `abort`:
  - Next edge: IDLE, `cv_valid` 0, counters 0.
  - No `done` pulse.
  - A beat pending in the same cycle is dropped, even if `cv_ready` is high.
- `start` while busy is ignored. `abort` and `start` in the same cycle: `abort` wins and the block stays IDLE.
- In IDLE the counters are 0, so the generator is addressed at (0,0).

## Timing
- Reset values: state IDLE; `busy`, `done`, `cv_valid`, `cv_last_frame`, `cv_last_class` = 0; `cv_data` and all tags = 0; `gen_frame_id` and `gen_frame_index` = 0.
- Reset mid-sweep clears everything immediately (asynchronous). The first `start` after reset is honoured.
- Start latency:
  - Edge k samples `start`, so `busy` = 1 after edge k.
  - First cap occurs at edge k+1, so `cv_valid` = 1 after edge k+1.
- Throughput: one beat per cycle while `cv_ready` = 1. A sweep is NUM_CLASSES*NUM_FRAMES beats.
- `done` is asserted for exactly the cycle after the edge that accepts the `cv_last_class` beat. In that same cycle `busy` = 0 and a new `start` is accepted.
- With `cv_ready` held at 1, the `done` pulse occurs N+2 cycles after `start` is sampled, where N = NUM_CLASSES*NUM_FRAMES.

## Test plan
- Default parameters, `cv_ready` = 1, `start` pulse:
  - 30 consecutive beats with tags (0,0),(0,1),(0,2),(1,0)…(9,2).
  - `cv_data` equals the generator output for each pair.
  - `cv_last_frame` is set on every third beat; `cv_last_class` only on beat 30.
  - `done` arrives 32 cycles after `start`.
- Random `cv_ready` backpressure at roughly 50%:
  - Same 30-beat ordered sequence with no drops or duplicates.
  - Data and tags are stable across every stall.
  - `done` pulses exactly once.
- `abort` asserted on the 14th beat while `cv_valid` & !`cv_ready`:
  - Next cycle: `cv_valid` = 0, `busy` = 0, no `done`.
  - A following `start` restarts at (0,0).
- Repeated `start` pulses during RUN and DRAIN: ignored; exactly 30 beats and one `done`. A `start` in the `done` cycle begins a new sweep.
- `rst_n` dropped mid-sweep at beat 7:
  - Outputs go to their reset values immediately, with no clock edge needed.
  - After release, `start` yields a full 30-beat sweep from (0,0).
- Parameters NUM_CLASSES = 3, NUM_FRAMES = 1:
  - Three beats with tags (0,0),(1,0),(2,0); `cv_last_frame` is set on all three.
  - `done` arrives 5 cycles after `start`.
